// File: rtl/rgb_seq_pkg.sv
// Shared types, palette and helpers for the RGB fade sequencer.
// Exports DUTY_MAX, state_e, rgb_t, PALETTE and step_toward().
package rgb_seq_pkg;

  localparam logic [7:0] DUTY_MAX = 8'd100;
  localparam int PAL_N = 6;

  typedef enum logic [1:0] {
    IDLE,
    FADE,
    HOLD,
    DONE
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // red, yellow, green, cyan, blue, magenta (0x64 = 100)
  localparam logic [23:0] PALETTE [PAL_N] = '{
    24'h64_00_00,
    24'h64_64_00,
    24'h00_64_00,
    24'h00_64_64,
    24'h00_00_64,
    24'h64_00_64
  };

  // one unit toward tgt, never overshooting or wrapping
  function automatic logic [7:0] step_toward(
    input logic [7:0] cur,
    input logic [7:0] tgt
  );
    logic [7:0] res;
    res = tgt;
    if (cur < tgt) res = cur + 8'd1;
    else if (cur > tgt) res = cur - 8'd1;
    return res;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_tick_gen.sv
// Step prescaler: counts 0..DIV-1 while en, tick on the last count.
// Ports: sys_clk, sys_rst_n, clr (sync clear), en, tick.
module rgb_seq_tick_gen #(
  parameter int DIV = 500_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Palette walker: fades each colour in, holds it, then moves on.
// Ports: sys_clk, sys_rst_n, start, abort -> busy, done, color_idx,
// out_R/G/B (0..100). Macro RGB_SEQ_LOOP_EN: wrap forever, no done.
import rgb_seq_pkg::*;

module rgb_fade_sequencer #(
  parameter int STEP_DIV   = 500_000,
  parameter int HOLD_STEPS = 50,
  parameter int N_COLORS   = 6,
  localparam int IDXW = (N_COLORS > 1) ? $clog2(N_COLORS) : 1
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] color_idx,
  output logic [7:0]      out_R,
  output logic [7:0]      out_G,
  output logic [7:0]      out_B
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_COLORS - 1);
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic [HW-1:0]   hold_q;
  logic [7:0]      r_q, g_q, b_q;
  logic            busy_q, done_q;

  rgb_t       tgt;
  logic [7:0] r_d, g_d, b_d;
  logic       at_tgt;
  logic       start_ok;
  logic       tick;

  assign tgt = rgb_t'(PALETTE[idx_q]);
  assign r_d = step_toward(r_q, tgt.r);
  assign g_d = step_toward(g_q, tgt.g);
  assign b_d = step_toward(b_q, tgt.b);
  assign at_tgt = (r_d == tgt.r) && (g_d == tgt.g) && (b_d == tgt.b);

  assign start_ok = start && !abort && (state_q == IDLE);

  rgb_seq_tick_gen #(
    .DIV(STEP_DIV)
  ) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (start_ok),
    .en       (busy_q),
    .tick     (tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FADE;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FADE: begin
          if (tick) begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
            if (at_tgt) begin
              state_q <= HOLD;
              hold_q  <= '0;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              if (idx_q != LAST_IDX) begin
                idx_q   <= idx_q + 1'b1;
                state_q <= FADE;
              end else begin
`ifdef RGB_SEQ_LOOP_EN
                idx_q   <= '0;
                state_q <= FADE;
`else
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`endif
              end
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign color_idx = idx_q;
  assign out_R     = r_q;
  assign out_G     = g_q;
  assign out_B     = b_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench: a step-level palette model predicts every cycle.
// Two DUTs (2 and 6 colours) share clock and reset; sel picks one.
module tb_rgb_fade_sequencer;

  localparam int D    = 2;
  localparam int HOLD = 3;
  localparam int PR [6] = '{100, 100, 0, 0, 0, 100};
  localparam int PG [6] = '{0, 100, 100, 100, 0, 0};
  localparam int PB [6] = '{0, 0, 0, 100, 100, 100};

  typedef struct {
    bit busy;
    bit done;
    int idx;
    int r;
    int g;
    int b;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st2 = 1'b0, ab2 = 1'b0, st6 = 1'b0, ab6 = 1'b0;
  logic bz2, dn2, bz6, dn6;
  logic [0:0] ix2;
  logic [2:0] ix6;
  logic [7:0] r2, g2, b2, r6, g6, b6;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(
    .STEP_DIV(D), .HOLD_STEPS(HOLD), .N_COLORS(2)
  ) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(st2), .abort(ab2),
    .busy(bz2), .done(dn2), .color_idx(ix2),
    .out_R(r2), .out_G(g2), .out_B(b2)
  );

  rgb_fade_sequencer #(
    .STEP_DIV(D), .HOLD_STEPS(HOLD), .N_COLORS(6)
  ) dut6 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(st6), .abort(ab6),
    .busy(bz6), .done(dn6), .color_idx(ix6),
    .out_R(r6), .out_G(g6), .out_B(b6)
  );

  snap_t q[$];
  snap_t idle_snap;
  snap_t last;
  bit sel = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int m_r = 0, m_g = 0, m_b = 0;

  function automatic snap_t mk(bit bz, bit dn, int ix,
                               int r, int g, int b);
    snap_t s;
    s.busy = bz; s.done = dn; s.idx = ix;
    s.r = r; s.g = g; s.b = b;
    return s;
  endfunction

  function automatic int toward(int cur, int tgt);
    return cur + ((tgt > cur) ? 1 : 0) - ((tgt < cur) ? 1 : 0);
  endfunction

  function automatic snap_t actual();
    if (sel) return mk(bz6, dn6, int'(ix6), int'(r6), int'(g6), int'(b6));
    return mk(bz2, dn2, int'(ix2), int'(r2), int'(g2), int'(b2));
  endfunction

  function automatic bit same(snap_t a, snap_t e);
    return a.busy == e.busy && a.done == e.done && a.idx == e.idx &&
           a.r == e.r && a.g == e.g && a.b == e.b;
  endfunction

  task automatic check(string name, snap_t a, snap_t e);
    vectors++;
    if (!same(a, e)) begin
      miscompares++;
      $display("FAIL %s t=%0t got b%0b d%0b i%0d (%0d,%0d,%0d) want b%0b d%0b i%0d (%0d,%0d,%0d)",
               name, $time, a.busy, a.done, a.idx, a.r, a.g, a.b,
               e.busy, e.done, e.idx, e.r, e.g, e.b);
    end
  endtask

  always @(negedge clk) begin
    snap_t e;
    cyc++;
    if (rst_n) begin
      if (q.size() > 0) e = q.pop_front();
      else e = idle_snap;
      check("cycle", actual(), e);
    end
  end

  task automatic set_in(bit s, bit a);
    st2 = sel ? 1'b0 : s;
    ab2 = sel ? 1'b0 : a;
    st6 = sel ? s : 1'b0;
    ab6 = sel ? a : 1'b0;
  endtask

  // D-1 unchanged cycles, then the step result
  task automatic tick_to(snap_t s);
    for (int k = 0; k < D - 1; k++) q.push_back(last);
    q.push_back(s);
    last = s;
  endtask

  task automatic gen(int n, int passes);
    int tr, tg, tb;
    last = mk(1, 0, 0, m_r, m_g, m_b);
    q.push_back(last);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < n; i++) begin
        tr = PR[i]; tg = PG[i]; tb = PB[i];
        do begin
          m_r = toward(m_r, tr);
          m_g = toward(m_g, tg);
          m_b = toward(m_b, tb);
          tick_to(mk(1, 0, i, m_r, m_g, m_b));
        end while (!(m_r == tr && m_g == tg && m_b == tb));
        for (int h = 1; h <= HOLD; h++) begin
          if (h < HOLD) tick_to(mk(1, 0, i, m_r, m_g, m_b));
          else if (i < n - 1) tick_to(mk(1, 0, i + 1, m_r, m_g, m_b));
`ifdef RGB_SEQ_LOOP_EN
          else tick_to(mk(1, 0, 0, m_r, m_g, m_b));
`else
          else begin
            tick_to(mk(0, 1, i, m_r, m_g, m_b));
            idle_snap = mk(0, 0, i, m_r, m_g, m_b);
            q.push_back(idle_snap);
          end
`endif
        end
      end
    end
  endtask

  task automatic idle(int n);
    set_in(0, 0);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(int n);
    q.push_back(idle_snap);
`ifdef RGB_SEQ_LOOP_EN
    gen(n, 3);
`else
    gen(n, 1);
`endif
    set_in(1, 0);
    @(posedge clk);
    #1;
    set_in(0, 0);
  endtask

  task automatic do_abort(bit with_start);
    snap_t f;
    if (q.size() > 0) begin
      f = q[0];
      q.delete();
      q.push_back(f);
    end else begin
      q.push_back(idle_snap);
    end
    idle_snap = mk(0, 0, 0, 0, 0, 0);
    q.push_back(idle_snap);
    m_r = 0; m_g = 0; m_b = 0;
    set_in(with_start, 1);
    @(posedge clk);
    #1;
    set_in(0, 0);
  endtask

  // run until the queue shrinks to stop, with stray starts while busy
  task automatic wait_q(int limit, int stop);
    int c = 0;
    bit s;
    while (q.size() > stop && c < limit) begin
      s = (q.size() > 2) && ($urandom_range(0, 15) == 0);
      set_in(s, 0);
      @(posedge clk);
      #1;
      c++;
    end
    set_in(0, 0);
    if (q.size() > stop) begin
      miscompares++;
      $display("FAIL timeout got %0d pending want %0d", q.size(), stop);
      q.delete();
    end
  endtask

  task automatic do_run(int n);
    do_start(n);
`ifdef RGB_SEQ_LOOP_EN
    wait_q(20000, 4);
    do_abort(0);
    idle(3);
`else
    wait_q(20000, 0);
`endif
  endtask

  initial begin
    int k;
    idle_snap = mk(0, 0, 0, 0, 0, 0);
    last = idle_snap;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // full single pass on the 2-colour unit
    idle($urandom_range(1, 5));
    do_run(2);
    idle(4);

    // start+abort together in IDLE blanks and stays idle
    do_abort(1);
    idle(3);

    // abort while red is at 40
    do_start(2);
    k = 0;
    while (!(q.size() > 0 && q[0].r == 40 && q[0].busy) && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 1000) begin
      miscompares++;
      $display("FAIL r40_wait got timeout want r=40");
    end
    do_abort(0);
    idle(4);

    // random abort points
    for (int t = 0; t < 4; t++) begin
      do_start(2);
      k = $urandom_range(1, 420);
      for (int c = 0; c < k && q.size() > 2; c++) begin
        @(posedge clk);
        #1;
      end
      do_abort(0);
      idle($urandom_range(2, 5));
    end

    // async reset mid-fade
    do_start(2);
    repeat ($urandom_range(5, 150)) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", actual(), mk(0, 0, 0, 0, 0, 0));
    q.delete();
    idle_snap = mk(0, 0, 0, 0, 0, 0);
    m_r = 0; m_g = 0; m_b = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // 6-colour unit: full pass, then restart from magenta
    sel = 1'b1;
    idle_snap = mk(0, 0, 0, 0, 0, 0);
    idle(2);
    do_run(6);
    idle(3);
    do_run(6);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
